// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, 8N1-style framing, LSB first, idle-high line.
// The line is brought into the clock domain through a two-flop synchronizer; a
// cycle counter places every sample at mid-bit. Each frame produces exactly one
// single-cycle strobe: valid for a good word, or frame_err (optionally with break)
// when the stop bit is sampled low.

`timescale 1ns/1ps

module uart_rx #(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_frame_err,
    output logic                    uart_rx_break
);

    // Clock cycles per bit period on the line.
    localparam int unsigned CPB    = CLK_HZ / BIT_RATE;
    localparam int unsigned CNT_W  = $clog2(CPB);
    localparam int unsigned BIDX_W = $clog2(PAYLOAD_BITS);

    // Start bit is checked half a bit in; data and stop bits one full bit later each.
    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(PAYLOAD_BITS - 1);
    localparam logic [BIDX_W-1:0] BIDX_ONE  = BIDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT
    } state_t;

    // Synchronizer stages.
    logic rxd_meta_q;
    logic rxd_s_q;

    // Receiver state.
    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [BIDX_W-1:0]       bidx_q;
    logic [PAYLOAD_BITS-1:0] shift_q;

    // Registered outputs.
    logic                    valid_q;
    logic [PAYLOAD_BITS-1:0] data_q;
    logic                    frame_err_q;
    logic                    break_q;

    // Two-flop synchronizer for the asynchronous serial line.
    // NOTE: both stages reset to 1 (idle level) so leaving reset never looks like
    // a falling start edge; non-blocking assignments keep the two stages a true
    // shift chain regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    // Frame FSM: start detection, mid-bit sampling, stop check and output strobes.
    // NOTE: the shift register is reset along with everything else so the break
    // comparison never sees undefined contents after reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bidx_q      <= '0;
            shift_q     <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            frame_err_q <= 1'b0;
            break_q     <= 1'b0;
        end else begin
            // Strobes are high for exactly one cycle; they default low every cycle.
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            break_q     <= 1'b0;

            if (!uart_rx_en && state_q != S_IDLE) begin
                // Receiver disabled mid-frame: drop the frame silently.
                state_q <= S_IDLE;
                cnt_q   <= '0;
                bidx_q  <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (uart_rx_en && !rxd_s_q) begin
                            state_q <= S_START;
                            cnt_q   <= '0;
                        end
                    end

                    S_START: begin
                        if (cnt_q == CNT_HALF) begin
                            cnt_q <= '0;
                            if (!rxd_s_q) begin
                                state_q <= S_DATA;
                                bidx_q  <= '0;
                            end else begin
                                // Line went back high before mid-start: a glitch.
                                state_q <= S_IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end

                    S_DATA: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q           <= '0;
                            shift_q[bidx_q] <= rxd_s_q;
                            if (bidx_q == BIDX_LAST) begin
                                state_q <= S_STOP;
                            end else begin
                                bidx_q <= bidx_q + BIDX_ONE;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end

                    S_STOP: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q <= '0;
                            if (rxd_s_q) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                                state_q <= S_IDLE;
                            end else begin
                                // Bad stop bit: keep the last good word, report the
                                // error, and wait for the line to go idle again.
                                frame_err_q <= 1'b1;
                                break_q     <= (shift_q == '0);
                                state_q     <= S_WAIT;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end

                    S_WAIT: begin
                        // A line held low must not be mistaken for a new start bit.
                        if (rxd_s_q) begin
                            state_q <= S_IDLE;
                        end
                    end

                    default: begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        bidx_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign uart_rx_valid     = valid_q;
    assign uart_rx_data      = data_q;
    assign uart_rx_frame_err = frame_err_q;
    assign uart_rx_break     = break_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at CLK_HZ=1 MHz, BIT_RATE=100 kbit/s
// (10 clocks per bit). Stimulus tasks push the expected strobe for each frame; a
// negedge monitor pops and compares whenever the DUT strobes.

`timescale 1ns/1ps

module tb_uart_rx;

    localparam int  CLK_HZ   = 1_000_000;
    localparam int  BIT_RATE = 100_000;
    localparam int  PB       = 8;
    localparam int  CPB      = CLK_HZ / BIT_RATE;
    localparam real CLK_NS   = 1000.0;
    localparam real BIT_NS   = 10000.0;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          uart_rxd = 1'b1;
    logic          uart_rx_en = 1'b0;
    logic          uart_rx_valid;
    logic [PB-1:0] uart_rx_data;
    logic          uart_rx_frame_err;
    logic          uart_rx_break;

    uart_rx #(
        .CLK_HZ      (CLK_HZ),
        .BIT_RATE    (BIT_RATE),
        .PAYLOAD_BITS(PB)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .uart_rxd         (uart_rxd),
        .uart_rx_en       (uart_rx_en),
        .uart_rx_valid    (uart_rx_valid),
        .uart_rx_data     (uart_rx_data),
        .uart_rx_frame_err(uart_rx_frame_err),
        .uart_rx_break    (uart_rx_break)
    );

    always #(CLK_NS / 2.0) clk = ~clk;

    typedef struct {
        logic          is_err;
        logic          brk;
        logic [PB-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    int            valid_cyc_q[$];
    int            n_pass = 0;
    int            n_total = 0;
    int            cyc = 0;
    logic [PB-1:0] last_good = '0;
    logic          prev_strobe = 1'b0;
    exp_t          mon_e;
    logic [10:0]   mon_got;
    logic [10:0]   mon_req;

    always @(posedge clk) cyc++;

    // Scoreboard monitor: every strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (uart_rx_valid || uart_rx_frame_err || uart_rx_break) begin
            n_total++;
            mon_got = {uart_rx_valid, uart_rx_frame_err, uart_rx_break, uart_rx_data};
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_strobe: got valid/ferr/brk/data=%b/%b/%b/%h, required no strobe",
                         uart_rx_valid, uart_rx_frame_err, uart_rx_break, uart_rx_data);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_req = {~mon_e.is_err, mon_e.is_err, mon_e.brk,
                           (mon_e.is_err ? last_good : mon_e.data)};
                if (mon_got !== mon_req) begin
                    $display("FAIL strobe_match: got valid/ferr/brk/data=%b/%b/%b/%h, required %b/%b/%b/%h",
                             mon_got[10], mon_got[9], mon_got[8], mon_got[7:0],
                             mon_req[10], mon_req[9], mon_req[8], mon_req[7:0]);
                end else begin
                    n_pass++;
                end
                if (!mon_e.is_err) last_good = mon_e.data;
            end
            if (uart_rx_valid) valid_cyc_q.push_back(cyc);
            n_total++;
            if (prev_strobe) begin
                $display("FAIL strobe_width: strobe high on consecutive cycles, required single cycle");
            end else begin
                n_pass++;
            end
        end
        prev_strobe = uart_rx_valid || uart_rx_frame_err || uart_rx_break;
    end

    // Global time limit so the run always ends on its own.
    initial begin
        #(20_000_000);
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic expect_word(input logic [PB-1:0] d);
        exp_q.push_back('{is_err: 1'b0, brk: 1'b0, data: d});
    endtask

    task automatic expect_err(input logic brk);
        exp_q.push_back('{is_err: 1'b1, brk: brk, data: '0});
    endtask

    // Place the next line edge 'off' ns after a rising clock edge.
    task automatic align(input real off);
        @(posedge clk);
        #(off);
    endtask

    // NOTE: line stimulus is driven with blocking assignments from tasks, timed in
    // ns so skewed bit periods need not be whole clock counts.
    task automatic send_frame(input logic [PB-1:0] d, input logic stop, input real bit_ns);
        uart_rxd = 1'b0;
        #(bit_ns);
        for (int i = 0; i < PB; i++) begin
            uart_rxd = d[i];
            #(bit_ns);
        end
        uart_rxd = stop;
        #(bit_ns);
    endtask

    task automatic idle(input real bits);
        uart_rxd = 1'b1;
        #(bits * BIT_NS);
    endtask

    // Wait (bounded) for all expected strobes, then check data holds the last good word.
    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL %s_drain: %0d strobes still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end else begin
            n_pass++;
        end
        n_total++;
        if (uart_rx_data !== last_good) begin
            $display("FAIL %s_data_hold: got %h, required %h", name, uart_rx_data, last_good);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        uart_rx_en = 1'b0;
        uart_rxd   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({uart_rx_valid, uart_rx_frame_err, uart_rx_break} !== 3'b000) begin
            $display("FAIL reset_strobes: got %b, required 000",
                     {uart_rx_valid, uart_rx_frame_err, uart_rx_break});
        end else begin
            n_pass++;
        end
        n_total++;
        if (uart_rx_data !== 8'h00) begin
            $display("FAIL reset_data: got %h, required 00", uart_rx_data);
        end else begin
            n_pass++;
        end
        last_good  = '0;
        resetn     = 1'b1;
        uart_rx_en = 1'b1;
        idle(1.0);
    endtask

    // Single frame; 'off' chooses where the start edge falls relative to the clock.
    task automatic test_single(input string name, input logic [PB-1:0] d,
                               input real bit_ns, input real off);
        align(off);
        expect_word(d);
        send_frame(d, 1'b1, bit_ns);
        idle(2.0);
        wait_drain(name);
    endtask

    task automatic test_back_to_back(input string name, input real bit_ns, input logic check_spacing);
        valid_cyc_q.delete();
        align(300.0);
        expect_word(8'h00);
        expect_word(8'hFF);
        expect_word(8'h3C);
        send_frame(8'h00, 1'b1, bit_ns);
        send_frame(8'hFF, 1'b1, bit_ns);
        send_frame(8'h3C, 1'b1, bit_ns);
        idle(2.0);
        wait_drain(name);
        if (check_spacing) begin
            n_total++;
            if (valid_cyc_q.size() != 3) begin
                $display("FAIL %s_count: got %0d valid strobes, required 3", name, valid_cyc_q.size());
            end else begin
                n_pass++;
                for (int i = 1; i < 3; i++) begin
                    n_total++;
                    if (valid_cyc_q[i] - valid_cyc_q[i-1] != 10 * CPB) begin
                        $display("FAIL %s_spacing: got %0d cycles, required %0d", name,
                                 valid_cyc_q[i] - valid_cyc_q[i-1], 10 * CPB);
                    end else begin
                        n_pass++;
                    end
                end
            end
        end
    endtask

    // Three-cycle low pulse must be rejected; a following frame proves the FSM is idle.
    task automatic test_glitch();
        align(300.0);
        uart_rxd = 1'b0;
        #(3.0 * CLK_NS);
        idle(2.0);
        align(300.0);
        expect_word(8'hC3);
        send_frame(8'hC3, 1'b1, BIT_NS);
        idle(2.0);
        wait_drain("glitch");
    endtask

    task automatic test_frame_err();
        align(300.0);
        expect_err(1'b0);
        send_frame(8'h55, 1'b0, BIT_NS);
        idle(2.0);
        align(300.0);
        expect_word(8'h12);
        send_frame(8'h12, 1'b1, BIT_NS);
        idle(2.0);
        wait_drain("frame_err");
    endtask

    task automatic test_break();
        align(300.0);
        expect_err(1'b1);
        uart_rxd = 1'b0;
        #(20.0 * BIT_NS);
        idle(2.0);
        wait_drain("break");
    endtask

    task automatic test_reset_mid_frame();
        align(300.0);
        // 0xF0: bits 0..3 low, bit 4 high, so the line is high while reset is applied.
        uart_rxd = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = 1'b0;
            #(BIT_NS);
        end
        uart_rxd = 1'b1;
        #(BIT_NS / 2.0);
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        last_good = '0;
        n_total++;
        if ({uart_rx_valid, uart_rx_data} !== 9'h000) begin
            $display("FAIL midreset_outputs: got valid/data=%b/%h, required 0/00",
                     uart_rx_valid, uart_rx_data);
        end else begin
            n_pass++;
        end
        resetn = 1'b1;
        idle(5.0);
        align(300.0);
        expect_word(8'h81);
        send_frame(8'h81, 1'b1, BIT_NS);
        idle(2.0);
        wait_drain("reset_mid_frame");
    endtask

    task automatic test_rx_en();
        align(300.0);
        fork
            send_frame(8'h66, 1'b1, BIT_NS);
            begin
                #(4.5 * BIT_NS);
                uart_rx_en = 1'b0;
            end
        join
        idle(1.0);
        // Whole frame while disabled: ignored.
        align(300.0);
        send_frame(8'h99, 1'b1, BIT_NS);
        idle(1.0);
        uart_rx_en = 1'b1;
        idle(1.0);
        align(300.0);
        expect_word(8'h5A);
        send_frame(8'h5A, 1'b1, BIT_NS);
        idle(2.0);
        wait_drain("rx_en");
    endtask

    initial begin
        test_reset();
        test_single("single_a5", 8'hA5, BIT_NS, 300.0);
        test_back_to_back("b2b", BIT_NS, 1'b1);
        test_glitch();
        test_frame_err();
        test_break();
        test_reset_mid_frame();
        test_rx_en();
        // Slow line (+3%): single frame and back-to-back.
        test_single("slow_a5", 8'hA5, BIT_NS * 1.03, 300.0);
        test_back_to_back("slow_b2b", BIT_NS * 1.03, 1'b0);
        // Fast line (-3%): start edge just before a clock edge keeps bit 7 sampled
        // inside its window; the stop sample lands on the idle-high line.
        test_single("fast_a5", 8'hA5, BIT_NS * 0.97, 950.0);
        test_single("fast_3c", 8'h3C, BIT_NS * 0.97, 950.0);
        idle(1.0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
